pattern_seq: RTL and testbench
==============================

PATTERN_SEQ -- requirements
Module: pattern_seq

Interface
REQ-001 Parameter DEPTH, default 8, number of table entries.
REQ-002 Parameter AW, default 3, table address width; DEPTH = 2**AW.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 wr_en  in  1  table write strobe.
REQ-006 wr_addr  in  AW  table entry to write.
REQ-007 wr_data  in  16  entry: [15:8] pattern byte, [7:0] pattern count.
REQ-008 seq_len  in  AW+1  entries to play per run, 0..DEPTH.
REQ-009 start  in  1  one-cycle run request.
REQ-010 abort  in  1  cancel run.
REQ-011 busy  out  1  run in progress.
REQ-012 done  out  1  one-cycle pulse on normal completion.
REQ-013 cur_idx  out  AW  index of entry being played.
REQ-014 pat_en  out  1  one-cycle start strobe to pattern generator.
REQ-015 pat_data  out  8  pattern byte to generator.
REQ-016 pat_cnt  out  8  pattern count to generator.
REQ-017 pat_rdy  in  1  generator idle/ready.

Function
REQ-018 States: IDLE, LOAD, ARM, FIRE, GUARD, WAIT, DONE.
REQ-019 IDLE: start=1 and seq_len!=0 -> LOAD, idx<=0; start=1 and seq_len=0 -> DONE; else stay.
REQ-020 LOAD: pat_data/pat_cnt <= table[idx] -> ARM.
REQ-021 ARM: pat_rdy=1 -> FIRE; else stay.
REQ-022 FIRE: lasts exactly one cycle -> GUARD; pat_en=1 only in FIRE.
REQ-023 GUARD: one cycle, pat_rdy ignored -> WAIT.
REQ-024 WAIT: pat_rdy=1 and idx=eff_len-1 -> DONE; pat_rdy=1 otherwise -> idx<=idx+1, LOAD; pat_rdy=0 -> stay.
REQ-025 DONE: done=1 for that cycle -> IDLE.
REQ-026 eff_len = min(seq_len, DEPTH), latched at start; seq_len changes mid-run have no effect.
REQ-027 busy=1 in LOAD, ARM, FIRE, GUARD, WAIT; 0 in IDLE and DONE.
REQ-028 Latency: start sampled at edge k, pat_rdy=1 -> pat_en high in cycle k+3.
REQ-029 pat_data/pat_cnt stable from LOAD of an entry until the next LOAD; held after run ends.
REQ-030 cur_idx = idx at all times.
REQ-031 Table writes accepted only when busy=0; writes while busy=1 dropped, table unchanged.
REQ-032 Write and start in same IDLE cycle: write commits, run uses new value.
REQ-033 start while busy=1 ignored.
REQ-034 abort=1 in any busy state -> IDLE next edge, no done, no further pat_en; abort beats start.
REQ-035 abort in FIRE: that pat_en cycle still occurs; generator not stopped by this block.
REQ-036 Run started after abort waits in ARM until pat_rdy=1.
REQ-037 Table contents undefined until written; not cleared by rst.

Reset
REQ-038 rst=1 -> state IDLE, idx=0, busy=0, done=0, pat_en=0, pat_data=0x00, pat_cnt=0x00 at next edge; overrides start/abort/wr_en.
REQ-039 rst mid-run: pat_en never asserted in cycle after rst sampled.

Verification
REQ-040 Write entry0={0x55,0x00}, entry1={0xAA,0x03}, seq_len=2, pat_rdy=1, start -> pat_en at k+3 with 0x55/0x00; after pat_rdy low then high, pat_en with 0xAA/0x03; done pulse once; busy low.
REQ-041 pat_rdy held 0 at start -> stay in ARM, no pat_en; raise pat_rdy -> pat_en next cycle.
REQ-042 seq_len=0, start -> done pulse at k+1, no pat_en, busy never high.
REQ-043 seq_len=12 (DEPTH=8) -> exactly 8 pat_en pulses, cur_idx 0..7, one done.
REQ-044 abort in WAIT of entry 1 of 4 -> IDLE next cycle, no done, no more pat_en; write during run ignored, readback via next run shows old data.
REQ-045 rst in GUARD -> all outputs reset values next cycle; new start replays from entry 0.

Source files
------------

// File: rtl/pattern_seq.sv
// Table-driven pattern sequencer: plays up to DEPTH {byte, count} entries to a
// downstream pattern generator, one strobe per entry, handshaking on pat_rdy.
module pattern_seq #(
    parameter int unsigned AW    = 3,
    parameter int unsigned DEPTH = 2**AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW:0]   seq_len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] cur_idx,
    output logic          pat_en,
    output logic [7:0]    pat_data,
    output logic [7:0]    pat_cnt,
    input  logic          pat_rdy
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_FIRE  = 3'd3,
        S_GUARD = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_e;

    state_e          state_q;
    logic [AW-1:0]   idx_q;
    logic [LW-1:0]   eff_len_q;
    logic            busy_q;
    logic            done_q;
    logic            pat_en_q;
    logic [7:0]      pat_data_q;
    logic [7:0]      pat_cnt_q;
    logic [15:0]     tbl_q [DEPTH];

    logic            last_c;
    logic [LW-1:0]   clamp_len_c;

    assign last_c      = (LW'(idx_q) == (eff_len_q - LW'(1)));
    assign clamp_len_c = (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;

    // Entry table: no reset, frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && !busy_q) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            eff_len_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pat_en_q   <= 1'b0;
            pat_data_q <= 8'h00;
            pat_cnt_q  <= 8'h00;
        end else begin
            done_q   <= 1'b0;
            pat_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (seq_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_LOAD;
                            idx_q     <= '0;
                            eff_len_q <= clamp_len_c;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    pat_data_q <= tbl_q[idx_q][15:8];
                    pat_cnt_q  <= tbl_q[idx_q][7:0];
                    state_q    <= S_ARM;
                end
                S_ARM: begin
                    if (pat_rdy) begin
                        state_q  <= S_FIRE;
                        pat_en_q <= 1'b1;
                    end
                end
                S_FIRE: begin
                    state_q <= S_GUARD;
                end
                // Generator may not have dropped pat_rdy yet; skip one sample.
                S_GUARD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (pat_rdy) begin
                        if (last_c) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + AW'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Abort wins over any transition taken above while busy.
            if (abort && busy_q) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
                pat_en_q <= 1'b0;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign cur_idx  = idx_q;
    assign pat_en   = pat_en_q;
    assign pat_data = pat_data_q;
    assign pat_cnt  = pat_cnt_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Scoreboard bench for pattern_seq: expected strobes/done pulses are queued by
// the stimulus thread and retired by a monitor thread sampling on negedge.
module tb_pattern_seq;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  seq_len;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [2:0]  cur_idx;
    logic        pat_en;
    logic [7:0]  pat_data;
    logic [7:0]  pat_cnt;
    logic        pat_rdy;

    pattern_seq #(.AW(3), .DEPTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .seq_len  (seq_len),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .cur_idx  (cur_idx),
        .pat_en   (pat_en),
        .pat_data (pat_data),
        .pat_cnt  (pat_cnt),
        .pat_rdy  (pat_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cnt;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   cmp_n;
    int   err_n;
    int   done_exp;
    int   done_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        cmp_n++;
        if (act !== expv) begin
            err_n++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] c, input logic [2:0] i);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        e.idx  = i;
        exp_q.push_back(e);
    endtask

    // Retires one queued entry per pat_en strobe and checks done pulses.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (pat_en === 1'b1) begin
                chk("pat_en_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pat_data", 32'(pat_data), 32'(e.data));
                    chk("pat_cnt",  32'(pat_cnt),  32'(e.cnt));
                    chk("cur_idx",  32'(cur_idx),  32'(e.idx));
                end
            end
            if (done === 1'b1) begin
                chk("done_expected", 32'(done_seen < done_exp), 32'd1);
                done_seen++;
            end
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic start_run(input logic [3:0] len);
        seq_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (i < budget && !(done_seen == done_exp && exp_q.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        chk("run_complete", 32'(done_seen == done_exp && exp_q.size() == 0), 32'd1);
        chk("busy_after_run", 32'(busy), 32'd0);
    endtask

    task automatic poll_strobe(input logic [2:0] i_want);
        int i;
        i = 0;
        while (i < 40 && !(pat_en === 1'b1 && cur_idx == i_want)) begin
            @(negedge clk);
            i++;
        end
        chk("strobe_seen", 32'(pat_en === 1'b1 && cur_idx == i_want), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_pat_en"},   32'(pat_en),   32'd0);
        chk({tag, "_pat_data"}, 32'(pat_data), 32'h00);
        chk({tag, "_pat_cnt"},  32'(pat_cnt),  32'h00);
        chk({tag, "_cur_idx"},  32'(cur_idx),  32'd0);
    endtask

    initial begin
        cmp_n = 0; err_n = 0; done_exp = 0; done_seen = 0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        seq_len = '0; start = 1'b0; abort = 1'b0; pat_rdy = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Two-entry run with k+3 strobe latency and a pat_rdy handshake
        wr(3'd0, 16'h5500);
        wr(3'd1, 16'hAA03);
        pat_rdy = 1'b1;
        push(8'h55, 8'h00, 3'd0);
        push(8'hAA, 8'h03, 3'd1);
        done_exp++;
        start_run(4'd2);
        chk("t1_busy_load", 32'(busy), 32'd1);
        chk("t1_no_strobe_load", 32'(pat_en), 32'd0);
        @(negedge clk);
        chk("t1_no_strobe_arm", 32'(pat_en), 32'd0);
        @(negedge clk);
        chk("t1_strobe_k3", 32'(pat_en), 32'd1);
        pat_rdy = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_busy_wait", 32'(busy), 32'd1);
        pat_rdy = 1'b1;
        wait_done(30);
        chk("t1_hold_data", 32'(pat_data), 32'hAA);
        chk("t1_hold_cnt",  32'(pat_cnt),  32'h03);

        // pat_rdy low at start: parks in ARM until it rises
        pat_rdy = 1'b0;
        start_run(4'd1);
        repeat (5) @(negedge clk);
        chk("t2_busy_arm", 32'(busy), 32'd1);
        push(8'h55, 8'h00, 3'd0);
        done_exp++;
        pat_rdy = 1'b1;
        @(negedge clk);
        chk("t2_strobe_next", 32'(pat_en), 32'd1);
        wait_done(20);

        // Zero-length run: done at k+1, never busy
        done_exp++;
        start_run(4'd0);
        chk("t3_done_k1", 32'(done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t3_done_once", 32'(done), 32'd0);
        chk("t3_busy_after", 32'(busy), 32'd0);

        // Over-long run clamps to DEPTH entries
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), {8'(32'h10 + i), 8'(i)});
        end
        for (int i = 0; i < 8; i++) begin
            push(8'(32'h10 + i), 8'(i), 3'(i));
        end
        done_exp++;
        start_run(4'd12);
        wait_done(80);
        chk("t4_last_idx", 32'(cur_idx), 32'd7);

        // Abort in WAIT of entry 1; a write during the run is dropped
        for (int i = 0; i < 4; i++) begin
            wr(3'(i), {8'(32'hA0 + i), 8'(i)});
        end
        push(8'hA0, 8'h00, 3'd0);
        push(8'hA1, 8'h01, 3'd1);
        start_run(4'd4);
        poll_strobe(3'd1);
        pat_rdy = 1'b0;
        wr(3'd0, 16'hFFFF);
        repeat (2) @(negedge clk);
        chk("t5_busy_wait", 32'(busy), 32'd1);
        chk("t5_idx_wait", 32'(cur_idx), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy_abort", 32'(busy), 32'd0);
        chk("t5_done_abort", 32'(done), 32'd0);
        pat_rdy = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        push(8'hA0, 8'h00, 3'd0);
        done_exp++;
        start_run(4'd1);
        wait_done(20);
        chk("t5_readback", 32'(pat_data), 32'hA0);

        // Reset while in GUARD, then replay from entry 0
        push(8'hA0, 8'h00, 3'd0);
        start_run(4'd2);
        poll_strobe(3'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_rst");
        rst = 1'b0;
        push(8'hA0, 8'h00, 3'd0);
        push(8'hA1, 8'h01, 3'd1);
        done_exp++;
        start_run(4'd2);
        wait_done(40);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("final_done_count", 32'(done_seen), 32'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
